// File: rtl/emilian_muxpga_if.sv
// Pin bundle of the emilian_muxpga tile: user inputs/outputs and the
// bidirectional pins that carry the serial configuration chain.
interface emilian_muxpga_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Driver side (harness or surrounding chip)
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // Tile side
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/emilian_muxpga.sv
// emilian_muxpga: eight 2-input LUT cells with optional output flops,
// configured through a 104-bit serial chain (13 bits per cell).
// Cell fields: [3:0] truth table, [7:4] selA, [11:8] selB, [12] registered.
// Source pool is {q[7:0], ui_in[7:0]}; feedback only passes through flops.
module emilian_muxpga (
  input  logic              clk,
  input  logic              rst_n,
  emilian_muxpga_if.slave   bus
);
  localparam int NCELL     = 8;
  localparam int CELL_BITS = 13;
  localparam int CHAIN     = NCELL * CELL_BITS;

  logic             cfg_en;
  logic             cfg_data;
  logic [CHAIN-1:0] cfg;
  logic [NCELL-1:0] q;
  logic [15:0]      pool;
  logic [NCELL-1:0] lut_out;
  logic [NCELL-1:0] cell_out;
  logic             unused_ok;

  // 2-input LUT lookup; B selects the upper half of the table
  function automatic logic lut2(input logic [3:0] t, input logic a, input logic b);
    return t[{b, a}];
  endfunction

  assign cfg_en    = bus.uio_in[0];
  assign cfg_data  = bus.uio_in[1];
  assign unused_ok = &{1'b0, bus.ena, bus.uio_in[7:2]};
  assign pool      = {q, bus.ui_in};

  // Config chain: shifts in one bit per enabled edge, first bit ends at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (cfg_en) begin
      cfg <= {cfg[CHAIN-2:0], cfg_data};
    end
  end

  // LUT evaluation and per-cell output select (flop or combinational path)
  always_comb begin
    lut_out  = '0;
    cell_out = '0;
    for (int i = 0; i < NCELL; i++) begin
      lut_out[i]  = lut2(cfg[CELL_BITS*i +: 4],
                         pool[cfg[CELL_BITS*i + 4 +: 4]],
                         pool[cfg[CELL_BITS*i + 8 +: 4]]);
      cell_out[i] = cfg[CELL_BITS*i + 12] ? q[i] : lut_out[i];
    end
  end

  // Cell flops: all cells update together, frozen while the chain is loading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!cfg_en) begin
      q <= lut_out;
    end
  end

  // Outputs are blanked during loading so partial configs never reach the pins
  assign bus.uo_out  = cfg_en ? 8'h00 : cell_out;
  assign bus.uio_out = {cfg[CHAIN-1], 7'b0};
  assign bus.uio_oe  = 8'h80;

endmodule

// File: tb/tb_emilian_muxpga.sv
// Directed bench for emilian_muxpga.
module tb_emilian_muxpga;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  emilian_muxpga_if bus ();

  emilian_muxpga dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [12:0] CELL_AND    = {1'b0, 4'd1, 4'd0, 4'b1000};
  localparam logic [12:0] CELL_TOGGLE = {1'b1, 4'd8, 4'd8, 4'b0001};
  localparam logic [103:0] PATTERN =
    {8'hDE, 32'hADBEEF01, 32'h23456789, 32'hABCDEF5A};

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Shift 104 bits MSB first, then drop cfg_en on the following negedge
  task automatic shift_cfg(input logic [103:0] v);
    for (int i = 103; i >= 0; i--) begin
      @(negedge clk);
      bus.uio_in = {6'b0, v[i], 1'b1};
      if (i == 52) begin
        #1;
        check("uo_blank_while_loading", {96'b0, bus.uo_out}, 104'h0);
      end
    end
    @(negedge clk);
    bus.uio_in = 8'h00;
  endtask

  initial begin
    logic [103:0] got;
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // 1: reset state
    #12;
    check("rst_uo_out",  {96'b0, bus.uo_out},  104'h00);
    check("rst_uio_out", {96'b0, bus.uio_out}, 104'h00);
    check("rst_uio_oe",  {96'b0, bus.uio_oe},  104'h80);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_uo_out",  {96'b0, bus.uo_out},  104'h00);
    check("post_rst_uio_out", {96'b0, bus.uio_out}, 104'h00);

    // 2: AND cell, combinational path
    shift_cfg({91'b0, CELL_AND});
    bus.ui_in = 8'h03; #1;
    check("and_11", {96'b0, bus.uo_out}, 104'h01);
    bus.ui_in = 8'h01; #1;
    check("and_01", {96'b0, bus.uo_out}, 104'h00);
    bus.ui_in = 8'h02; #1;
    check("and_10", {96'b0, bus.uo_out}, 104'h00);
    bus.ui_in = 8'hFF; #1;
    check("and_ff", {96'b0, bus.uo_out}, 104'h01);
    bus.ui_in = 8'h00;

    // 3: toggle cell through its own flop
    do_reset();
    shift_cfg({91'b0, CELL_TOGGLE});
    #1;
    check("toggle_start", {96'b0, bus.uo_out}, 104'h00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("toggle_edge", {96'b0, bus.uo_out}, (k % 2 == 0) ? 104'h01 : 104'h00);
    end

    // 5: freeze while reloading the same config, then resume from held q
    @(posedge clk); #1;
    check("toggle_before_freeze", {96'b0, bus.uo_out}, 104'h01);
    shift_cfg({91'b0, CELL_TOGGLE});
    #1;
    check("resume_held", {96'b0, bus.uo_out}, 104'h01);
    @(posedge clk); #1;
    check("resume_next", {96'b0, bus.uo_out}, 104'h00);

    // 6: async reset between edges kills the fabric
    @(posedge clk); #1;
    check("toggle_before_rst", {96'b0, bus.uo_out}, 104'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo", {96'b0, bus.uo_out}, 104'h00);
    check("async_rst_uio", {96'b0, bus.uio_out}, 104'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("dead_after_rst", {96'b0, bus.uo_out}, 104'h00);

    // 4: readback of a full pattern through the chain tail
    shift_cfg(PATTERN);
    #1;
    got = '0;
    got[103] = bus.uio_out[7];
    check("readback_first", {96'b0, bus.uio_out}, {96'b0, PATTERN[103], 7'b0});
    for (int k = 1; k < 104; k++) begin
      @(negedge clk);
      bus.uio_in = 8'h01;
      @(posedge clk); #1;
      got[103-k] = bus.uio_out[7];
    end
    @(negedge clk);
    bus.uio_in = 8'h00;
    check("readback_pattern", got, PATTERN);
    check("readback_oe", {96'b0, bus.uio_oe}, 104'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
